// File: rtl/alu_pkg.sv
// alu_pkg: shared opcode, flag-bit and FSM-state definitions for the ALU slice.
// Used by the issue controller, its interface and the settle counter.
package alu_pkg;

    localparam int OPW = 5;

    localparam logic [OPW-1:0] OP_NOP = 5'b00000;
    localparam logic [OPW-1:0] OP_ADD = 5'b00001;
    localparam logic [OPW-1:0] OP_SUB = 5'b00010;
    localparam logic [OPW-1:0] OP_AND = 5'b01010;
    localparam logic [OPW-1:0] OP_OR  = 5'b01011;
    localparam logic [OPW-1:0] OP_XOR = 5'b01100;

    localparam int FLAG_Z = 0;
    localparam int FLAG_N = 1;
    localparam int FLAG_C = 2;
    localparam int FLAG_V = 3;

    localparam int CNTW = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

endpackage

// File: rtl/alu_issue_ctrl_if.sv
// alu_issue_ctrl_if: command, ALU-side and response signals of the issue controller.
// slave = the controller itself, master = its surroundings (datapath ctrl + alu).
interface alu_issue_ctrl_if
    import alu_pkg::*;
#(
    parameter int W = 16
);
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic [OPW-1:0]        cmd_op;
    logic                  cmd_load;
    logic                  cmd_use_acc;
    logic signed [W-1:0]   cmd_a;
    logic signed [W-1:0]   cmd_b;
    logic [OPW-1:0]        alu_op;
    logic signed [W-1:0]   alu_a;
    logic signed [W-1:0]   alu_b;
    logic signed [W-1:0]   alu_result;
    logic [3:0]            alu_flags;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic signed [W-1:0]   rsp_result;
    logic [3:0]            rsp_flags;

    modport slave (
        input  cmd_valid, cmd_op, cmd_load, cmd_use_acc, cmd_a, cmd_b,
        input  alu_result, alu_flags, rsp_ready,
        output cmd_ready, alu_op, alu_a, alu_b,
        output rsp_valid, rsp_result, rsp_flags
    );

    modport master (
        output cmd_valid, cmd_op, cmd_load, cmd_use_acc, cmd_a, cmd_b,
        output alu_result, alu_flags, rsp_ready,
        input  cmd_ready, alu_op, alu_a, alu_b,
        input  rsp_valid, rsp_result, rsp_flags
    );

endinterface

// File: rtl/alu_issue_settle_cnt.sv
// alu_issue_settle_cnt: loadable down-counter timing the ALU settle window.
// Stops at zero; zero is flagged combinationally.
import alu_pkg::*;

module alu_issue_settle_cnt (
    input  logic            clk,
    input  logic            rst,
    input  logic            load,
    input  logic [CNTW-1:0] load_val,
    input  logic            dec,
    output logic            zero
);

    logic [CNTW-1:0] cnt;

    // load takes priority; otherwise count down and park at zero
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: one-outstanding-command sequencer in front of the combinational alu.
// Optional macro ALU_ISSUE_STICKY_FLAGS_EN makes rsp_flags accumulate across ALU ops.
import alu_pkg::*;

module alu_issue_ctrl #(
    parameter int W      = 16,
    parameter int SETTLE = 2
) (
    input  logic                clk,
    input  logic                rst,
    alu_issue_ctrl_if.slave     io,
    output logic signed [W-1:0] acc
);

    localparam logic [CNTW-1:0] SETTLE_M1 = CNTW'(SETTLE - 1);

    state_t              state_q;
    state_t              state_d;
    logic                take;
    logic                capture;
    logic                cnt_load;
    logic                cnt_zero;
    logic signed [W-1:0] opnd_a;
    logic [OPW-1:0]      op_q;
    logic signed [W-1:0] a_q;
    logic signed [W-1:0] b_q;
    logic signed [W-1:0] res_q;
    logic [3:0]          flg_q;

    assign take    = (state_q == IDLE) && io.cmd_valid;
    assign capture = (state_q == ISSUE) && cnt_zero;
    assign opnd_a  = io.cmd_use_acc ? acc : io.cmd_a;

    alu_issue_settle_cnt u_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (cnt_load),
        .load_val (SETTLE_M1),
        .dec      (state_q == ISSUE),
        .zero     (cnt_zero)
    );

    // state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // next-state and handshake outputs
    always_comb begin
        state_d      = state_q;
        cnt_load     = 1'b0;
        io.cmd_ready = 1'b0;
        io.rsp_valid = 1'b0;
        unique case (state_q)
            IDLE: begin
                io.cmd_ready = 1'b1;
                if (io.cmd_valid) begin
                    state_d  = io.cmd_load ? RESP : ISSUE;
                    cnt_load = !io.cmd_load;
                end
            end
            ISSUE: begin
                if (cnt_zero) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                io.rsp_valid = 1'b1;
                if (io.rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // operand latch, accumulator and response capture
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q  <= OP_NOP;
            a_q   <= '0;
            b_q   <= '0;
            acc   <= '0;
            res_q <= '0;
            flg_q <= '0;
        end else if (take) begin
            if (io.cmd_load) begin
                acc   <= io.cmd_b;
                res_q <= io.cmd_b;
`ifdef ALU_ISSUE_STICKY_FLAGS_EN
                flg_q <= '0;
`endif
            end else begin
                op_q <= io.cmd_op;
                a_q  <= opnd_a;
                b_q  <= io.cmd_b;
            end
        end else if (capture) begin
            acc   <= io.alu_result;
            res_q <= io.alu_result;
`ifdef ALU_ISSUE_STICKY_FLAGS_EN
            flg_q <= flg_q | io.alu_flags;
`else
            flg_q <= io.alu_flags;
`endif
        end
    end

    assign io.alu_op     = op_q;
    assign io.alu_a      = a_q;
    assign io.alu_b      = b_q;
    assign io.rsp_result = res_q;
    assign io.rsp_flags  = flg_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb_alu_issue_ctrl: directed vectors against alu_issue_ctrl with an OR-only alu model.
// Flag model: Z = result zero, N = result sign; C/V stay 0.
import alu_pkg::*;

module tb_alu_issue_ctrl;

    localparam int W      = 16;
    localparam int SETTLE = 3;

    logic                clk;
    logic                rst;
    logic signed [W-1:0] acc;
    int                  n_chk;
    int                  n_fail;
    logic [3:0]          exp_flags;
    int                  lat;

    alu_issue_ctrl_if #(.W(W)) bus ();

    alu_issue_ctrl #(.W(W), .SETTLE(SETTLE)) dut (
        .clk (clk),
        .rst (rst),
        .io  (bus.slave),
        .acc (acc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // combinational alu stand-in
    assign bus.alu_result = (bus.alu_op == OP_OR) ? (bus.alu_a | bus.alu_b) : '0;
    assign bus.alu_flags  = {2'b00, bus.alu_result[W-1], bus.alu_result == '0};

    task automatic check(input string tag, input int got, input int exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic logic [3:0] fl(input int r);
        return {2'b00, r < 0, r == 0};
    endfunction

    // issue one command from a negedge; returns cycles until rsp_valid seen
    task automatic do_cmd(input logic ld, input logic ua,
                          input int a, input int b, output int l);
        logic [OPW-1:0]      op0;
        logic signed [W-1:0] a0;
        logic signed [W-1:0] b0;
        int                  bad;
        bus.cmd_valid   = 1'b1;
        bus.cmd_op      = OP_OR;
        bus.cmd_load    = ld;
        bus.cmd_use_acc = ua;
        bus.cmd_a       = W'(a);
        bus.cmd_b       = W'(b);
        @(posedge clk);
        #1 bus.cmd_valid = 1'b0;
        @(negedge clk);
        op0 = bus.alu_op;
        a0  = bus.alu_a;
        b0  = bus.alu_b;
        bad = 0;
        l   = 0;
        while (!bus.rsp_valid && l < 20) begin
            if (bus.alu_op !== op0 || bus.alu_a !== a0 || bus.alu_b !== b0)
                bad++;
            @(negedge clk);
            l++;
        end
        if (!ld) check("issue_stable", bad, 0);
    endtask

    task automatic take_rsp();
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        bus.rsp_ready = 1'b0;
    endtask

    // expected rsp_flags after an ALU result r
    function automatic logic [3:0] nxt_flags(input logic [3:0] cur, input int r);
`ifdef ALU_ISSUE_STICKY_FLAGS_EN
        return cur | fl(r);
`else
        return fl(r);
`endif
    endfunction

    function automatic logic [3:0] load_flags(input logic [3:0] cur);
`ifdef ALU_ISSUE_STICKY_FLAGS_EN
        return 4'b0000 & cur;
`else
        return cur;
`endif
    endfunction

    int va [5] = '{-32, -13, 9, 16, 16};
    int vb [5] = '{5, -3, 1, 11, -10};
    int vr [5] = '{-27, -1, 9, 27, -10};

    initial begin
        n_chk           = 0;
        n_fail          = 0;
        exp_flags       = 4'b0000;
        rst             = 1'b1;
        bus.cmd_valid   = 1'b0;
        bus.cmd_op      = OP_NOP;
        bus.cmd_load    = 1'b0;
        bus.cmd_use_acc = 1'b0;
        bus.cmd_a       = '0;
        bus.cmd_b       = '0;
        bus.rsp_ready   = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        check("rst_cmd_ready", bus.cmd_ready, 1);
        check("rst_rsp_valid", bus.rsp_valid, 0);
        check("rst_acc", acc, 0);
        check("rst_alu_a", bus.alu_a, 0);
        check("rst_alu_b", bus.alu_b, 0);
        check("rst_alu_op", bus.alu_op, 0);
        check("rst_rsp_result", bus.rsp_result, 0);
        check("rst_rsp_flags", bus.rsp_flags, 0);

        for (int i = 0; i < 5; i++) begin
            do_cmd(1'b0, 1'b0, va[i], vb[i], lat);
            exp_flags = nxt_flags(exp_flags, vr[i]);
            check($sformatf("or%0d_lat", i), lat, SETTLE);
            check($sformatf("or%0d_res", i), bus.rsp_result, vr[i]);
            check($sformatf("or%0d_acc", i), acc, vr[i]);
            check($sformatf("or%0d_flags", i), bus.rsp_flags, exp_flags);
            take_rsp();
            check($sformatf("or%0d_ready", i), bus.cmd_ready, 1);
        end

        do_cmd(1'b1, 1'b0, 0, 16, lat);
        exp_flags = load_flags(exp_flags);
        check("load_lat", lat, 0);
        check("load_res", bus.rsp_result, 16);
        check("load_acc", acc, 16);
        check("load_flags", bus.rsp_flags, exp_flags);
        take_rsp();

        do_cmd(1'b0, 1'b1, 0, 11, lat);
        exp_flags = nxt_flags(exp_flags, 27);
        check("chain1_acc", acc, 27);
        check("chain1_res", bus.rsp_result, 27);
        take_rsp();

        do_cmd(1'b0, 1'b1, 0, -32, lat);
        exp_flags = nxt_flags(exp_flags, -5);
        check("chain2_acc", acc, -5);
        check("chain2_flags", bus.rsp_flags, exp_flags);
        take_rsp();

        do_cmd(1'b0, 1'b0, 9, 1, lat);
        exp_flags = nxt_flags(exp_flags, 9);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_res", bus.rsp_result, 9);
            check("bp_flags", bus.rsp_flags, exp_flags);
            check("bp_cmd_ready", bus.cmd_ready, 0);
            check("bp_rsp_valid", bus.rsp_valid, 1);
        end
        take_rsp();
        check("bp_ready_after", bus.cmd_ready, 1);
        check("bp_valid_after", bus.rsp_valid, 0);

        do_cmd(1'b1, 1'b0, 0, 0, lat);
        exp_flags = load_flags(exp_flags);
        take_rsp();
        do_cmd(1'b0, 1'b0, 0, 0, lat);
        exp_flags = nxt_flags(exp_flags, 0);
        check("sticky1_flags", bus.rsp_flags, exp_flags);
        take_rsp();
        do_cmd(1'b0, 1'b0, -32, 5, lat);
        exp_flags = nxt_flags(exp_flags, -27);
`ifdef ALU_ISSUE_STICKY_FLAGS_EN
        check("sticky2_flags", bus.rsp_flags, 4'b0011);
`else
        check("sticky2_flags", bus.rsp_flags, 4'b0010);
`endif
        check("sticky2_model", bus.rsp_flags, exp_flags);
        take_rsp();

        bus.cmd_valid   = 1'b1;
        bus.cmd_load    = 1'b0;
        bus.cmd_use_acc = 1'b0;
        bus.cmd_a       = W'(9);
        bus.cmd_b       = W'(1);
        @(posedge clk);
        #1 bus.cmd_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("rstmid_rsp_valid", bus.rsp_valid, 0);
        check("rstmid_acc", acc, 0);
        check("rstmid_cmd_ready", bus.cmd_ready, 1);
        @(negedge clk);
        rst = 1'b0;
        exp_flags = 4'b0000;
        @(negedge clk);
        do_cmd(1'b0, 1'b0, 16, 11, lat);
        exp_flags = nxt_flags(exp_flags, 27);
        check("post_rst_lat", lat, SETTLE);
        check("post_rst_res", bus.rsp_result, 27);
        check("post_rst_flags", bus.rsp_flags, exp_flags);
        take_rsp();

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
